// File: rtl/rv_lsu_pkg.sv
// rtl/rv_lsu_pkg.sv - opcodes, funct3 codes and FSM states for the MEM-stage load/store unit
package rv_lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/rv_lsu_align.sv
// rtl/rv_lsu_align.sv - byte-lane steering, load extension and alignment/legality check
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        bad
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Decode size from funct3: store lane enables/replication, or load extraction/extension.
  always_comb begin
    be        = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    bad       = 1'b0;
    if (store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{rs2[7:0]}};
        end
        F3_SH: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{rs2[15:0]}};
          bad   = addr_lo[0];
        end
        F3_SW: begin
          be    = 4'b1111;
          wdata = rs2;
          bad   = (addr_lo != 2'b00);
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
        F3_LBU: load_data = {24'h0, lane_byte};
        F3_LH: begin
          load_data = {{16{lane_half[15]}}, lane_half};
          bad       = addr_lo[0];
        end
        F3_LHU: begin
          load_data = {16'h0, lane_half};
          bad       = addr_lo[0];
        end
        F3_LW: begin
          load_data = rdata;
          bad       = (addr_lo != 2'b00);
        end
        default: bad = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - MEM-stage load/store unit: bus FSM, op latch, timeout and MEM/WB register
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_ir,
  input  logic [31:0] ex_mem_alu_out,
  input  logic [31:0] ex_mem_rs2,
  output logic        mem_ex_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_ir,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_exc
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

  lsu_state_e state, state_nxt;
  logic [CW-1:0] count;

  // The memory op is consumed from EX/MEM at acceptance, so everything needed later is latched.
  logic [31:0] lat_ir, lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_we;

  logic        idle, is_load, is_store, is_mem, timeout;
  logic        al_store, al_bad;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;

  logic        retire, ret_exc;
  logic [31:0] ret_ir, ret_res;

  assign idle     = (state == ST_IDLE);
  assign is_load  = (ex_mem_ir[6:0] == OP_LOAD);
  assign is_store = (ex_mem_ir[6:0] == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign timeout  = (WAIT_MAX != 0) && (count == LIMIT);

  // In IDLE the helper decodes the incoming op; afterwards it decodes the latched op for load data.
  assign al_store = idle ? is_store : lat_we;
  assign al_f3    = idle ? ex_mem_ir[14:12] : lat_ir[14:12];
  assign al_off   = idle ? ex_mem_alu_out[1:0] : lat_addr[1:0];

  rv_lsu_align u_align (
    .store     (al_store),
    .funct3    (al_f3),
    .addr_lo   (al_off),
    .rs2       (ex_mem_rs2),
    .rdata     (dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_ldata),
    .bad       (al_bad)
  );

  assign mem_ex_stall = !idle;
  assign dmem_req     = (state == ST_REQ);
  assign dmem_we      = dmem_req && lat_we;
  assign dmem_addr    = dmem_req ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign dmem_be      = dmem_req ? lat_be : 4'b0000;
  assign dmem_wdata   = dmem_req ? lat_wdata : 32'h0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the retire event with its write-back payload; gnt/rvalid win over timeout.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    ret_ir    = lat_ir;
    ret_res   = lat_addr;
    ret_exc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_mem_valid) begin
          if (is_mem && !al_bad) begin
            state_nxt = ST_REQ;
          end else begin
            retire  = 1'b1;
            ret_ir  = ex_mem_ir;
            ret_res = ex_mem_alu_out;
            ret_exc = is_mem;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (lat_we) begin
            state_nxt = ST_IDLE;
            retire    = 1'b1;
          end else begin
            state_nxt = ST_RESP;
          end
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          retire    = 1'b1;
          ret_exc   = 1'b1;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          state_nxt = ST_IDLE;
          retire    = 1'b1;
          ret_res   = al_ldata;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          retire    = 1'b1;
          ret_exc   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: runs while a transaction is open and parks at the limit so a gnt-won race still times out in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (idle)     count <= '0;
    else if (!timeout) count <= count + 1'b1;
  end

  // Capture the accepted memory op so the bus fields stay stable while EX moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_ir    <= 32'h0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_be    <= 4'b0000;
      lat_we    <= 1'b0;
    end else if (idle && ex_mem_valid && is_mem && !al_bad) begin
      lat_ir    <= ex_mem_ir;
      lat_addr  <= ex_mem_alu_out;
      lat_wdata <= al_wdata;
      lat_be    <= al_be;
      lat_we    <= is_store;
    end
  end

  // MEM/WB register: one-cycle valid pulse per retire, payload holds between retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_valid  <= 1'b0;
      mem_wb_ir     <= 32'h0;
      mem_wb_result <= 32'h0;
      mem_wb_exc    <= 1'b0;
    end else begin
      mem_wb_valid <= retire;
      if (retire) begin
        mem_wb_ir     <= ret_ir;
        mem_wb_result <= ret_res;
        mem_wb_exc    <= ret_exc;
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - randomized self-checking bench for rv_lsu against a behavioural model
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mem_valid = 1'b0;
  logic [31:0] ex_mem_ir = '0, ex_mem_alu_out = '0, ex_mem_rs2 = '0;
  logic        mem_ex_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_wb_valid, mem_wb_exc;
  logic [31:0] mem_wb_ir, mem_wb_result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ADD   = 7'b0110011;

  typedef struct packed {
    int          n_retire;
    int          stall_cyc;
    int          req_cyc;
    int          latency;
    logic [31:0] ir;
    logic [31:0] res;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exc;
    logic        we;
    logic        stable;
  } obs_t;

  rv_lsu #(.WAIT_MAX(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_mem_valid   (ex_mem_valid),
    .ex_mem_ir      (ex_mem_ir),
    .ex_mem_alu_out (ex_mem_alu_out),
    .ex_mem_rs2     (ex_mem_rs2),
    .mem_ex_stall   (mem_ex_stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_wb_valid   (mem_wb_valid),
    .mem_wb_ir      (mem_wb_ir),
    .mem_wb_result  (mem_wb_result),
    .mem_wb_exc     (mem_wb_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = op;
    r[14:12] = f3;
    return r;
  endfunction

  // Architectural meaning of one instruction given the data the bus would return.
  function automatic void model(input logic [31:0] ir, alu, rs2, rdata,
                                output bit bus, output bit we, output bit exc,
                                output logic [31:0] result, output logic [3:0] be,
                                output logic [31:0] wdata);
    int f3, off, size;
    bit legal;
    logic [31:0] sh;
    f3 = int'(ir[14:12]);
    off = int'(alu % 4);
    bus = 0; we = 0; exc = 0; result = alu; be = 0; wdata = 0;
    if (ir[6:0] == OPC_LOAD) begin
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
      if (!legal || (off % size) != 0) exc = 1;
      else begin
        bus = 1;
        sh = rdata >> (8 * off);
        if (size == 1) begin
          result = sh & 32'hFF;
          if (f3 == 0 && result >= 128) result = result | 32'hFFFFFF00;
        end else if (size == 2) begin
          result = sh & 32'hFFFF;
          if (f3 == 1 && result >= 32768) result = result | 32'hFFFF0000;
        end else result = rdata;
      end
    end else if (ir[6:0] == OPC_STORE) begin
      size = 1 << f3;
      if (f3 > 2 || (off % size) != 0) exc = 1;
      else begin
        bus = 1; we = 1;
        be = 4'(((1 << size) - 1) << off);
        wdata = (size == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
                (size == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
      end
    end
  endfunction

  // Issue one instruction and play the memory side; returns what was observed (no judging here).
  task automatic exec(input logic [31:0] ir, alu, rs2, rdata,
                      input int gnt_dly, input int rv_dly, input bit late_rv, output obs_t o);
    int req_seen, resp_seen, post;
    o = '0;
    o.stable = 1'b1;
    req_seen = 0; resp_seen = 0; post = 0;
    @(negedge clk);
    ex_mem_valid = 1'b1; ex_mem_ir = ir; ex_mem_alu_out = alu; ex_mem_rs2 = rs2;
    for (int cyc = 1; cyc <= 40 && post < 3; cyc++) begin
      @(negedge clk);
      ex_mem_valid = 1'b0;
      ex_mem_ir = $urandom; ex_mem_alu_out = $urandom; ex_mem_rs2 = $urandom;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (mem_wb_valid) begin
        o.n_retire++;
        if (o.n_retire == 1) begin
          o.ir = mem_wb_ir; o.res = mem_wb_result; o.exc = mem_wb_exc; o.latency = cyc;
        end
      end
      if (mem_ex_stall) o.stall_cyc++;
      if (dmem_req) begin
        if (req_seen == 0) begin
          o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
        end else if ({o.addr, o.be, o.wdata, o.we} !== {dmem_addr, dmem_be, dmem_wdata, dmem_we})
          o.stable = 1'b0;
        if (req_seen == gnt_dly) dmem_gnt = 1'b1;
        req_seen++;
      end else if (mem_ex_stall) begin
        if (resp_seen == rv_dly) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
        resp_seen++;
      end
      if (o.n_retire > 0 && !mem_ex_stall) begin
        post++;
        if (late_rv) dmem_rvalid = 1'b1;
      end
    end
    dmem_rvalid = 1'b0;
    dmem_gnt = 1'b0;
    o.req_cyc = req_seen;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({mem_ex_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_wb_valid,
         mem_wb_ir, mem_wb_result, mem_wb_exc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got req=%b stall=%b wbv=%b res=%h ir=%h want all zero",
               dmem_req, mem_ex_stall, mem_wb_valid, mem_wb_result, mem_wb_ir);
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    obs_t o;
    logic [31:0] ir;
    ir = mk_ir(OPC_ADD, 3'd0);
    exec(ir, 32'h1234, 32'h0, 32'h0, 0, 0, 0, o);
    n_checks++;
    if ({o.n_retire, o.latency, o.res, o.ir, o.exc, o.stall_cyc, o.req_cyc} !==
        {32'd1, 32'd1, 32'h1234, ir, 1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL add_pass got n=%0d lat=%0d res=%h exc=%b stall=%0d want 1 1 00001234 0 0",
               o.n_retire, o.latency, o.res, o.exc, o.stall_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, ib;
    ia = mk_ir(OPC_ADD, 3'd0);
    ib = mk_ir(OPC_ADD, 3'd7);
    @(negedge clk);
    ex_mem_valid = 1'b1; ex_mem_ir = ia; ex_mem_alu_out = 32'hAAAA0001;
    @(negedge clk);
    n_checks++;
    if ({mem_wb_valid, mem_wb_ir, mem_wb_result} !== {1'b1, ia, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL b2b_first got v=%b res=%h want 1 aaaa0001", mem_wb_valid, mem_wb_result);
    end
    ex_mem_ir = ib; ex_mem_alu_out = 32'h5555_0002;
    @(negedge clk);
    n_checks++;
    if ({mem_wb_valid, mem_wb_ir, mem_wb_result} !== {1'b1, ib, 32'h55550002}) begin
      n_fail++;
      $display("FAIL b2b_second got v=%b res=%h want 1 55550002", mem_wb_valid, mem_wb_result);
    end
    ex_mem_valid = 1'b0; ex_mem_alu_out = 32'hDEAD0000;
    @(negedge clk);
    n_checks++;
    if ({mem_wb_valid, mem_wb_result} !== {1'b0, 32'h55550002}) begin
      n_fail++;
      $display("FAIL b2b_hold got v=%b res=%h want 0 55550002", mem_wb_valid, mem_wb_result);
    end
  endtask

  task automatic test_store_sb();
    obs_t o;
    exec(mk_ir(OPC_STORE, 3'd0), 32'h103, 32'h000000A5, 32'h0, 3, 0, 0, o);
    n_checks++;
    if ({o.addr, o.be, o.wdata, o.we, o.stable} !== {32'h100, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sb_bus got addr=%h be=%b wdata=%h we=%b stable=%b want 00000100 1000 a5a5a5a5 1 1",
               o.addr, o.be, o.wdata, o.we, o.stable);
    end
    n_checks++;
    if ({o.n_retire, o.stall_cyc, o.exc, o.res} !== {32'd1, 32'd4, 1'b0, 32'h103}) begin
      n_fail++;
      $display("FAIL sb_retire got n=%0d stall=%0d exc=%b res=%h want 1 4 0 00000103",
               o.n_retire, o.stall_cyc, o.exc, o.res);
    end
  endtask

  task automatic test_load_ext();
    obs_t o;
    exec(mk_ir(OPC_LOAD, 3'd0), 32'h202, 32'h0, 32'h00800000, 0, 0, 0, o);
    n_checks++;
    if ({o.res, o.latency, o.addr} !== {32'hFFFFFF80, 32'd3, 32'h200}) begin
      n_fail++;
      $display("FAIL lb_sext got res=%h lat=%0d addr=%h want ffffff80 3 00000200", o.res, o.latency, o.addr);
    end
    exec(mk_ir(OPC_LOAD, 3'd4), 32'h202, 32'h0, 32'h00800000, 1, 2, 0, o);
    n_checks++;
    if (o.res !== 32'h00000080) begin
      n_fail++;
      $display("FAIL lbu_zext got %h want 00000080", o.res);
    end
    exec(mk_ir(OPC_LOAD, 3'd5), 32'h202, 32'h0, 32'hBEEF0000, 0, 1, 0, o);
    n_checks++;
    if (o.res !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL lhu_zext got %h want 0000beef", o.res);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    exec(mk_ir(OPC_LOAD, 3'd2), 32'h301, 32'h0, 32'h0, 0, 0, 0, o);
    n_checks++;
    if ({o.req_cyc, o.exc, o.res, o.latency} !== {32'd0, 1'b1, 32'h301, 32'd1}) begin
      n_fail++;
      $display("FAIL lw_misalign got req=%0d exc=%b res=%h lat=%0d want 0 1 00000301 1",
               o.req_cyc, o.exc, o.res, o.latency);
    end
    exec(mk_ir(OPC_LOAD, 3'd3), 32'h300, 32'h0, 32'h0, 0, 0, 0, o);
    n_checks++;
    if ({o.req_cyc, o.exc} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ld_f3_3 got req=%0d exc=%b want 0 1", o.req_cyc, o.exc);
    end
    exec(mk_ir(OPC_STORE, 3'd1), 32'h101, 32'h0, 32'h0, 0, 0, 0, o);
    n_checks++;
    if ({o.req_cyc, o.exc, o.res} !== {32'd0, 1'b1, 32'h101}) begin
      n_fail++;
      $display("FAIL sh_misalign got req=%0d exc=%b res=%h want 0 1 00000101", o.req_cyc, o.exc, o.res);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    exec(mk_ir(OPC_STORE, 3'd2), 32'h500, 32'h12345678, 32'h0, 1000, 0, 1, o);
    n_checks++;
    if ({o.n_retire, o.exc, o.res, o.req_cyc, o.latency} !== {32'd1, 1'b1, 32'h500, 32'd8, 32'd9}) begin
      n_fail++;
      $display("FAIL timeout got n=%0d exc=%b res=%h req=%0d lat=%0d want 1 1 00000500 8 9",
               o.n_retire, o.exc, o.res, o.req_cyc, o.latency);
    end
    exec(mk_ir(OPC_STORE, 3'd2), 32'h504, 32'h12345678, 32'h0, 7, 0, 0, o);
    n_checks++;
    if ({o.n_retire, o.exc, o.res, o.req_cyc} !== {32'd1, 1'b0, 32'h504, 32'd8}) begin
      n_fail++;
      $display("FAIL gnt_at_limit got n=%0d exc=%b res=%h req=%0d want 1 0 00000504 8",
               o.n_retire, o.exc, o.res, o.req_cyc);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    ex_mem_valid = 1'b1; ex_mem_ir = mk_ir(OPC_LOAD, 3'd2); ex_mem_alu_out = 32'h400;
    @(negedge clk);
    ex_mem_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    n_checks++;
    if ({mem_ex_stall, dmem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_in_resp got stall=%b req=%b want 1 0", mem_ex_stall, dmem_req);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_ex_stall, dmem_req, dmem_addr, mem_wb_valid, mem_wb_result, mem_wb_exc} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got stall=%b req=%b wbv=%b res=%h want all zero",
               mem_ex_stall, dmem_req, mem_wb_valid, mem_wb_result);
    end
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_wb_valid, mem_ex_stall, mem_wb_result} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_late_rvalid got wbv=%b stall=%b res=%h want 0 0 00000000",
               mem_wb_valid, mem_ex_stall, mem_wb_result);
    end
    exec(mk_ir(OPC_LOAD, 3'd2), 32'h404, 32'h0, 32'h600DD00D, 0, 0, 0, o);
    n_checks++;
    if ({o.n_retire, o.res, o.exc} !== {32'd1, 32'h600DD00D, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_then_lw got n=%0d res=%h exc=%b want 1 600dd00d 0", o.n_retire, o.res, o.exc);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] ir, alu, rs2, rdata, e_res, e_wdata;
    logic [3:0]  e_be;
    bit e_bus, e_we, e_exc;
    int kind, g, rv, e_lat;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) ir = mk_ir(($urandom_range(0, 1) == 0) ? OPC_ADD : 7'b0010011, 3'($urandom));
      else if (kind == 1) ir = mk_ir(OPC_LOAD, 3'($urandom_range(0, 7)));
      else ir = mk_ir(OPC_STORE, 3'($urandom_range(0, 3)));
      alu = $urandom; rs2 = $urandom; rdata = $urandom;
      g = $urandom_range(0, 2); rv = $urandom_range(0, 2);
      model(ir, alu, rs2, rdata, e_bus, e_we, e_exc, e_res, e_be, e_wdata);
      exec(ir, alu, rs2, rdata, g, rv, 0, o);
      e_lat = !e_bus ? 1 : e_we ? g + 2 : g + rv + 3;
      n_checks++;
      if ({o.n_retire, o.ir, o.res, o.exc, o.latency} !== {32'd1, ir, e_res, e_exc, e_lat}) begin
        n_fail++;
        $display("FAIL rand_retire[%0d] got n=%0d res=%h exc=%b lat=%0d want 1 %h %b %0d",
                 i, o.n_retire, o.res, o.exc, o.latency, e_res, e_exc, e_lat);
      end
      n_checks++;
      if ((o.req_cyc != 0) !== e_bus) begin
        n_fail++;
        $display("FAIL rand_bus[%0d] got req_cycles=%0d want bus=%b", i, o.req_cyc, e_bus);
      end
      if (e_bus) begin
        n_checks++;
        if ({o.addr, o.we, o.stable} !== {alu & 32'hFFFFFFFC, e_we, 1'b1} ||
            (e_we && {o.be, o.wdata} !== {e_be, e_wdata})) begin
          n_fail++;
          $display("FAIL rand_busfields[%0d] got addr=%h we=%b be=%b wd=%h st=%b want %h %b %b %h 1",
                   i, o.addr, o.we, o.be, o.wdata, o.stable, alu & 32'hFFFFFFFC, e_we, e_be, e_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_store_sb();
    test_load_ext();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
